// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter for four requesters with burst locking onto a shared FIFO
module fifo_wr_arb #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  input  logic               fifo_full,
  output logic [3:0]         gnt,
  output logic               fifo_w_en,
  output logic [WIDTH-1:0]   fifo_din,
  output logic [1:0]         owner,
  output logic               locked
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, owner_n, sel, idx;
  logic [3:0] cnt, cnt_n;
  logic found, xfer, last;
  // descending scan so the requester closest to ptr wins
  always_comb begin
    sel = ptr;
    found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        sel = ptr + 2'(k);
        found = 1'b1;
      end
    end
  end
  assign locked = state == LOCK;
  assign idx = locked ? owner : sel;
  assign gnt = (rst || fifo_full || !(locked ? req[owner] : found)) ? 4'd0 : 4'd1 << idx;
  assign xfer = |(req & gnt);
  assign fifo_w_en = xfer;
  assign fifo_din = xfer ? din[idx*WIDTH +: WIDTH] : '0;
  assign last = cnt + 4'd1 == 4'(BURST);
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    cnt_n = cnt;
    if (!locked) begin
      if (xfer && BURST == 1) ptr_n = sel + 2'd1;
      else if (xfer) begin
        state_n = LOCK;
        owner_n = sel;
        cnt_n = 4'd1;
      end
    end else if (!req[owner] || (xfer && last)) begin
      state_n = IDLE;
      ptr_n = owner + 2'd1;
      owner_n = 2'd0;
      cnt_n = 4'd0;
    end else if (xfer) cnt_n = cnt + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 2'd0;
      owner <= 2'd0;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: scoreboard bench running BURST=1 and BURST=4 arbiters side by side
module tb_fifo_wr_arb;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic fifo_full = 1'b0;
  logic [4*W-1:0] din [2];
  logic [3:0] gnt [2];
  logic w_en [2];
  logic [W-1:0] fdin [2];
  logic [1:0] own [2];
  logic lck [2];
  always #5 clk = ~clk;
  fifo_wr_arb #(.WIDTH(W), .BURST(1)) u1 (.clk(clk), .rst(rst), .req(req), .din(din[0]), .fifo_full(fifo_full),
    .gnt(gnt[0]), .fifo_w_en(w_en[0]), .fifo_din(fdin[0]), .owner(own[0]), .locked(lck[0]));
  fifo_wr_arb #(.WIDTH(W), .BURST(4)) u4 (.clk(clk), .rst(rst), .req(req), .din(din[1]), .fifo_full(fifo_full),
    .gnt(gnt[1]), .fifo_w_en(w_en[1]), .fifo_din(fdin[1]), .owner(own[1]), .locked(lck[1]));
  typedef struct packed {logic [3:0] gg; logic lk; logic [1:0] ow;} exp_t;
  exp_t cq [2][$];
  logic [W-1:0] wq [2][$];
  int hold [2];
  int taken [2];
  int start [2];
  int seq [2][4];
  int bursts [2] = '{1, 4};
  int checks = 0;
  int errors = 0;
  bit done = 0;
  task automatic chk(string name, int n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s burst=%0d got %0h expected %0h", name, bursts[n], act, exp);
    end
  endtask
  // model: a holder keeps the FIFO until it stops asking or has used its burst allowance
  function automatic int pick(int n, logic [3:0] r, logic f, logic rs);
    if (rs || f) return -1;
    if (hold[n] >= 0) return r[hold[n]] ? hold[n] : -1;
    for (int k = 0; k < 4; k++) if (r[(start[n] + k) % 4]) return (start[n] + k) % 4;
    return -1;
  endfunction
  function automatic logic [W-1:0] word(int n, int i);
    return W'(i * 64 + seq[n][i] % 64);
  endfunction
  task automatic cyc(logic [3:0] r, logic f, logic rs);
    int g [2];
    req = r;
    fifo_full = f;
    rst = rs;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 4; i++) din[n][i*W +: W] = word(n, i);
      g[n] = pick(n, r, f, rs);
      cq[n].push_back(exp_t'{gg: g[n] >= 0 ? 4'(1 << g[n]) : 4'd0, lk: hold[n] >= 0,
                             ow: hold[n] >= 0 ? 2'(hold[n]) : 2'd0});
      if (g[n] >= 0) wq[n].push_back(word(n, g[n]));
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (g[n] >= 0) seq[n][g[n]]++;
      if (rs) begin
        hold[n] = -1;
        taken[n] = 0;
        start[n] = 0;
      end else if (hold[n] >= 0) begin
        if (g[n] >= 0) taken[n]++;
        if (!r[hold[n]] || taken[n] == bursts[n]) begin
          start[n] = (hold[n] + 1) % 4;
          hold[n] = -1;
          taken[n] = 0;
        end
      end else if (g[n] >= 0) begin
        if (bursts[n] == 1) start[n] = (g[n] + 1) % 4;
        else begin
          hold[n] = g[n];
          taken[n] = 1;
        end
      end
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!done) begin
      for (int n = 0; n < 2; n++) begin
        if (cq[n].size() > 0) begin
          e = cq[n].pop_front();
          chk("gnt", n, 32'(gnt[n]), 32'(e.gg));
          chk("locked", n, 32'(lck[n]), 32'(e.lk));
          chk("owner", n, 32'(own[n]), 32'(e.ow));
          chk("w_en", n, 32'(w_en[n]), 32'(e.gg != 4'd0));
          if (!w_en[n]) chk("din_idle", n, 32'(fdin[n]), 32'd0);
        end
        if (w_en[n]) begin
          if (wq[n].size() == 0) chk("write_extra", n, 32'd1, 32'd0);
          else chk("fifo_din", n, 32'(fdin[n]), 32'(wq[n].pop_front()));
          if (fifo_full) chk("write_while_full", n, 32'd1, 32'd0);
        end
      end
    end
  end
  initial begin
    for (int n = 0; n < 2; n++) begin
      hold[n] = -1;
      taken[n] = 0;
      start[n] = 0;
      for (int i = 0; i < 4; i++) seq[n][i] = 0;
    end
    @(posedge clk);
    #1;
    repeat (3) cyc(4'hf, 1'b0, 1'b1);
    repeat (8) cyc(4'hf, 1'b0, 1'b0);
    cyc(4'h0, 1'b0, 1'b1);
    repeat (12) cyc(4'h5, 1'b0, 1'b0);
    cyc(4'h0, 1'b0, 1'b1);
    repeat (2) cyc(4'h2, 1'b0, 1'b0);
    repeat (3) cyc(4'h2, 1'b1, 1'b0);
    repeat (3) cyc(4'h2, 1'b0, 1'b0);
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h8, 1'b0, 1'b0);
    repeat (3) cyc(4'h1, 1'b0, 1'b0);
    cyc(4'h0, 1'b0, 1'b1);
    repeat (2) cyc(4'h4, 1'b0, 1'b0);
    repeat (2) cyc(4'hf, 1'b0, 1'b1);
    repeat (4) cyc(4'hf, 1'b0, 1'b0);
    repeat (1500) cyc(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    cyc(4'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    done = 1;
    for (int n = 0; n < 2; n++) begin
      chk("words_left", n, 32'(wq[n].size()), 32'd0);
      chk("cycles_left", n, 32'(cq[n].size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
